parking_zone_ctrl: RTL and testbench
====================================

# parking_zone_ctrl

Multi-zone parking lot controller, the parametrised successor of the single-counter parking-spot block. Tracks free spots per zone for NUM_ZONES zones and arbitrates a single entry gate through a request/grant/deny handshake with a timed gate-open phase. Exit events are per-zone pulses and may arrive in any cycle. It sits between the gate sensors and ticket logic and the lot status display and billing logic.

## Interface
- NUM_ZONES, 4: number of zones (1..16)
- ZONE_CAP, 16: spots per zone (1..255)
- CNT_W, 5: per-zone counter width; must hold ZONE_CAP
- ZONE_W, 2: width of the zone select; must hold NUM_ZONES-1
- TOT_W, 7: width of total_free; must hold NUM_ZONES*ZONE_CAP
- GATE_HOLD, 8: cycles gate_open stays high after a grant (>=1)
- RESERVE, 2: per-zone spots kept for priority entries (only used with PARKING_RESERVE_EN)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- entry_req  in  1  level request; held by the requester until entry_grant or entry_deny
- entry_zone  in  ZONE_W  requested zone, valid while entry_req is high
- entry_priority  in  1  priority request (see Configuration)
- exit_evt  in  NUM_ZONES  one bit per zone; a 1-cycle pulse means one car left that zone; several bits may be set together
- entry_grant  out  1  1-cycle pulse; entry accepted
- entry_deny  out  1  1-cycle pulse; entry refused
- gate_open  out  1  entry gate open
- free_cnt  out  NUM_ZONES*CNT_W  free spots per zone; zone i is in bits [i*CNT_W +: CNT_W]
- zone_full  out  NUM_ZONES  bit i is high when free_cnt[i]==0
- lot_full  out  1  high when all zones are full
- total_free  out  TOT_W  sum of all free_cnt values
- err_exit  out  1  sticky flag: an exit arrived for a zone that already has free==ZONE_CAP

## Operation
- Reset state: FSM in IDLE; every free_cnt = ZONE_CAP; total_free = NUM_ZONES*ZONE_CAP; zone_full = 0; lot_full = 0; gate_open = 0; entry_grant = 0; entry_deny = 0; err_exit = 0; gate timer = 0.
- FSM states: IDLE, GATE.
- **IDLE with entry_req high:**
  - If entry_zone < NUM_ZONES and free_cnt[zone] > 0, the controller decrements that zone, pulses entry_grant, loads the timer with GATE_HOLD, and moves to GATE.
  - Otherwise it pulses entry_deny and stays in IDLE.
- **GATE:**
  - gate_open = 1 and the timer counts down once per cycle.
  - When the timer reaches 1, the FSM returns to IDLE, so gate_open is high for exactly GATE_HOLD cycles.
  - entry_req is ignored in GATE; it is re-evaluated in IDLE.
- **Exit:** for each set bit i of exit_evt, free_cnt[i] increments if it is below ZONE_CAP. If free_cnt[i] is already ZONE_CAP, the count is unchanged and err_exit is set. err_exit clears only on reset.
- **Grant and exit in the same zone and same cycle:** the net change is 0. It is not an error, even when free==ZONE_CAP.
- **Grant on a zone with free==0 while that zone exits in the same cycle:** this is denied. The decision uses the pre-edge count.
- total_free is a registered counter updated on the same edge as free_cnt: minus 1 per grant, plus the number of accepted exits.
- zone_full and lot_full are combinational from the registered counters.
- Reset while in GATE: gate_open drops at the next edge and the counters are restored to full.

## Timing
- A request sampled at edge N produces entry_grant or entry_deny high during cycle N+1 (1 cycle latency).
- On a grant, free_cnt, total_free and gate_open all change at edge N.
- A requester that drops entry_req after seeing the grant or deny pulse is never double-served, because the FSM is in GATE after a grant.
- After a deny, the requester must drop entry_req in cycle N+1. If it does not, it is re-evaluated and denied again.
- Exits take effect at the sampling edge; there is no exit latency beyond the register.

## Configuration
- PARKING_RESERVE_EN defined: a request with entry_priority=0 is granted only if free_cnt[zone] > RESERVE. Priority requests use the normal > 0 rule. Non-priority requests refused by this rule get entry_deny.
- PARKING_RESERVE_EN undefined: entry_priority and RESERVE are ignored, and every request uses the > 0 rule.

## Test plan
- Reset then idle: free_cnt all 16, total_free 64, lot_full 0, err_exit 0, gate_open 0.
- Request zone 2 -> entry_grant pulse next cycle; free_cnt[2]=15; total_free=63; gate_open high exactly 8 cycles.
- Fill zone 0 with 16 grants, then a 17th request -> entry_deny; zone_full[0]=1; exit_evt[0] pulse -> free_cnt[0]=1 and zone_full[0]=0.
- Grant to zone 1 with exit_evt=4'b0011 in the same cycle and zone 1 at 10 -> free_cnt[1]=10; zone 0 unchanged at 16 with err_exit=1; entry_zone=3'd… out of range (ZONE_W=3, NUM_ZONES=4, zone 5) -> deny.
- With PARKING_RESERVE_EN and zone 3 at 2 free: non-priority request -> deny; priority request -> grant and free_cnt[3]=1.
- Assert reset mid-GATE -> gate_open=0 and all free_cnt=16 on the next edge.

Source files
------------

// File: rtl/parking_zone_ctrl.sv
// Multi-zone parking controller: per-zone free counters, entry gate handshake, timed gate-open phase.
// Optional macro PARKING_RESERVE_EN keeps RESERVE spots per zone for priority entries.
module parking_zone_ctrl #(
  parameter int NUM_ZONES = 4,
  parameter int ZONE_CAP  = 16,
  parameter int CNT_W     = 5,
  parameter int ZONE_W    = 2,
  parameter int TOT_W     = 7,
  parameter int GATE_HOLD = 8,
  parameter int RESERVE   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       entry_req,
  input  logic [ZONE_W-1:0]          entry_zone,
  input  logic                       entry_priority,
  input  logic [NUM_ZONES-1:0]       exit_evt,
  output logic                       entry_grant,
  output logic                       entry_deny,
  output logic                       gate_open,
  output logic [NUM_ZONES*CNT_W-1:0] free_cnt,
  output logic [NUM_ZONES-1:0]       zone_full,
  output logic                       lot_full,
  output logic [TOT_W-1:0]           total_free,
  output logic                       err_exit
);

  typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

  localparam int TMR_W = $clog2(GATE_HOLD + 1);
  localparam logic [CNT_W-1:0] CAP_L = CNT_W'(ZONE_CAP);

  state_t             state_r;
  logic [TMR_W-1:0]   timer_r;
  logic               gate_r;
  logic               grant_r;
  logic               deny_r;
  logic               err_r;
  logic [CNT_W-1:0]   free_r [NUM_ZONES];
  logic [TOT_W-1:0]   total_r;

  logic [CNT_W-1:0]   free_nxt_s [NUM_ZONES];
  logic [TOT_W-1:0]   total_nxt_s;
  logic               err_hit_s;
  logic [CNT_W-1:0]   sel_free_s;
  logic               zone_ok_s;
  logic [CNT_W-1:0]   need_s;
  logic               req_grant_s;
  logic               req_deny_s;
  logic               hit_s;

  // Look up the requested zone's count; out-of-range zones match nothing.
  always_comb begin
    sel_free_s = '0;
    zone_ok_s  = 1'b0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      sel_free_s = (entry_zone == ZONE_W'(i)) ? free_r[i] : sel_free_s;
      zone_ok_s  = (entry_zone == ZONE_W'(i)) ? 1'b1 : zone_ok_s;
    end
  end

`ifdef PARKING_RESERVE_EN
  // Non-priority entries must leave RESERVE spots behind.
  always_comb begin
    need_s = entry_priority ? '0 : CNT_W'(RESERVE);
  end
`else
  logic unused_s;
  assign unused_s = entry_priority ^ RESERVE[0];
  // Every entry just needs one free spot.
  always_comb begin
    need_s = '0;
  end
`endif

  assign req_grant_s = (state_r == IDLE) && entry_req && zone_ok_s && (sel_free_s > need_s);
  assign req_deny_s  = (state_r == IDLE) && entry_req && !req_grant_s;

  // Next counter values; grant and exit on the same zone cancel out without error.
  always_comb begin
    total_nxt_s = total_r;
    err_hit_s   = 1'b0;
    hit_s       = 1'b0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      hit_s         = req_grant_s && (entry_zone == ZONE_W'(i));
      free_nxt_s[i] = free_r[i];
      if (hit_s && exit_evt[i]) begin
        free_nxt_s[i] = free_r[i];
      end else if (hit_s) begin
        free_nxt_s[i] = free_r[i] - CNT_W'(1);
        total_nxt_s   = total_nxt_s - TOT_W'(1);
      end else if (exit_evt[i]) begin
        if (free_r[i] == CAP_L) begin
          err_hit_s = 1'b1;
        end else begin
          free_nxt_s[i] = free_r[i] + CNT_W'(1);
          total_nxt_s   = total_nxt_s + TOT_W'(1);
        end
      end else begin
        free_nxt_s[i] = free_r[i];
      end
    end
  end

  // Gate FSM, handshake pulses and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      timer_r <= '0;
      gate_r  <= 1'b0;
      grant_r <= 1'b0;
      deny_r  <= 1'b0;
      err_r   <= 1'b0;
      total_r <= TOT_W'(NUM_ZONES * ZONE_CAP);
      for (int i = 0; i < NUM_ZONES; i++) free_r[i] <= CAP_L;
    end else begin
      grant_r <= req_grant_s;
      deny_r  <= req_deny_s;
      err_r   <= err_r | err_hit_s;
      total_r <= total_nxt_s;
      for (int i = 0; i < NUM_ZONES; i++) free_r[i] <= free_nxt_s[i];
      case (state_r)
        IDLE: begin
          if (req_grant_s) begin
            state_r <= GATE;
            timer_r <= TMR_W'(GATE_HOLD);
            gate_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            timer_r <= '0;
            gate_r  <= 1'b0;
          end
        end
        GATE: begin
          if (timer_r == TMR_W'(1)) begin
            state_r <= IDLE;
            timer_r <= '0;
            gate_r  <= 1'b0;
          end else begin
            timer_r <= timer_r - TMR_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          timer_r <= '0;
          gate_r  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_ZONES; g++) begin : g_out
    assign free_cnt[g*CNT_W +: CNT_W] = free_r[g];
    assign zone_full[g]               = (free_r[g] == '0);
  end

  assign lot_full    = &zone_full;
  assign entry_grant = grant_r;
  assign entry_deny  = deny_r;
  assign gate_open   = gate_r;
  assign total_free  = total_r;
  assign err_exit    = err_r;

endmodule

// File: tb/tb_parking_zone_ctrl.sv
// Directed self-checking bench for parking_zone_ctrl (4 zones x 16 spots, 3-bit zone select).
module tb_parking_zone_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        entry_req = 1'b0;
  logic [2:0]  entry_zone = 3'd0;
  logic        entry_priority = 1'b0;
  logic [3:0]  exit_evt = 4'd0;
  logic        entry_grant, entry_deny, gate_open, lot_full, err_exit;
  logic [19:0] free_cnt;
  logic [3:0]  zone_full;
  logic [6:0]  total_free;

  int total = 0;
  int bad = 0;

  parking_zone_ctrl #(.NUM_ZONES(4), .ZONE_CAP(16), .CNT_W(5), .ZONE_W(3),
                      .TOT_W(7), .GATE_HOLD(8), .RESERVE(2)) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .entry_zone(entry_zone),
    .entry_priority(entry_priority), .exit_evt(exit_evt), .entry_grant(entry_grant),
    .entry_deny(entry_deny), .gate_open(gate_open), .free_cnt(free_cnt),
    .zone_full(zone_full), .lot_full(lot_full), .total_free(total_free), .err_exit(err_exit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [19:0] fv(input int z0, input int z1, input int z2, input int z3);
    fv = {5'(z3), 5'(z2), 5'(z1), 5'(z0)};
  endfunction

  task automatic req(input int zone, input logic prio, input logic [3:0] ex,
                     output logic g, output logic d);
    @(negedge clk);
    entry_req = 1'b1; entry_zone = 3'(zone); entry_priority = prio; exit_evt = ex;
    @(negedge clk);
    g = entry_grant; d = entry_deny;
    entry_req = 1'b0; exit_evt = 4'd0; entry_priority = 1'b0;
  endtask

  task automatic wait_gate(output int n);
    n = 0;
    while (gate_open && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic g, d;
  int n, ng;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_free", free_cnt, fv(16, 16, 16, 16));
    chk("rst_total", total_free, 64);
    chk("rst_lot_full", lot_full, 0);
    chk("rst_err", err_exit, 0);
    chk("rst_gate", gate_open, 0);
    chk("rst_zone_full", zone_full, 0);

    // single grant on zone 2 and gate-open duration
    req(2, 1'b0, 4'd0, g, d);
    chk("z2_grant", g, 1);
    chk("z2_deny", d, 0);
    chk("z2_free", free_cnt, fv(16, 16, 15, 16));
    chk("z2_total", total_free, 63);
    wait_gate(n);
    chk("gate_cycles", n, 8);
    chk("grant_pulse_gone", entry_grant, 0);

    // bring zone 1 down to 10
    ng = 0;
    for (int i = 0; i < 6; i++) begin
      req(1, 1'b0, 4'd0, g, d);
      ng += int'(g);
      wait_gate(n);
    end
    chk("z1_grants", ng, 6);
    chk("z1_free10", free_cnt, fv(16, 10, 15, 16));

    // grant zone 1 with exits on zones 0 and 1 together
    req(1, 1'b0, 4'b0011, g, d);
    chk("mix_grant", g, 1);
    chk("mix_free", free_cnt, fv(16, 10, 15, 16));
    chk("mix_err", err_exit, 1);
    chk("mix_total", total_free, 57);
    wait_gate(n);

    // out-of-range zone
    req(5, 1'b0, 4'd0, g, d);
    chk("oor_deny", d, 1);
    chk("oor_grant", g, 0);
    chk("oor_total", total_free, 57);

    // fill zone 0
    ng = 0;
    for (int i = 0; i < 16; i++) begin
      req(0, 1'b0, 4'd0, g, d);
      ng += int'(g);
      wait_gate(n);
    end
    chk("z0_grants", ng, 16);
    chk("z0_empty", free_cnt, fv(0, 10, 15, 16));
    chk("z0_full_flag", zone_full, 4'b0001);
    chk("z0_total", total_free, 41);
    chk("z0_lot_full", lot_full, 0);
    req(0, 1'b0, 4'd0, g, d);
    chk("z0_17th_deny", d, 1);
    chk("z0_17th_grant", g, 0);
    @(negedge clk);
    chk("deny_pulse_gone", entry_deny, 0);
    // request on an empty zone while it exits: denied, exit still counts
    req(0, 1'b0, 4'b0001, g, d);
    chk("z0_exit_deny", d, 1);
    chk("z0_exit_free", free_cnt, fv(1, 10, 15, 16));
    chk("z0_exit_zf", zone_full, 4'b0000);
    chk("z0_exit_total", total_free, 42);

    // zone 3 down to 2, then reserve behaviour
    ng = 0;
    for (int i = 0; i < 14; i++) begin
      req(3, 1'b0, 4'd0, g, d);
      ng += int'(g);
      wait_gate(n);
    end
    chk("z3_grants", ng, 14);
    chk("z3_total", total_free, 28);
    req(3, 1'b0, 4'd0, g, d);
`ifdef PARKING_RESERVE_EN
    chk("res_np_deny", d, 1);
    chk("res_np_free", free_cnt, fv(1, 10, 15, 2));
    req(3, 1'b1, 4'd0, g, d);
    chk("res_prio_grant", g, 1);
`else
    chk("nores_grant", g, 1);
`endif
    chk("z3_free1", free_cnt, fv(1, 10, 15, 1));
    chk("z3_total2", total_free, 27);
    wait_gate(n);

    // two exits in one cycle
    @(negedge clk);
    exit_evt = 4'b1100;
    @(negedge clk);
    exit_evt = 4'd0;
    chk("multi_exit_free", free_cnt, fv(1, 10, 16, 2));
    chk("multi_exit_total", total_free, 29);
    chk("err_sticky", err_exit, 1);

    // reset while the gate is open
    req(2, 1'b0, 4'd0, g, d);
    chk("pre_rst_grant", g, 1);
    @(negedge clk);
    chk("pre_rst_gate", gate_open, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_gate", gate_open, 0);
    chk("mid_rst_free", free_cnt, fv(16, 16, 16, 16));
    chk("mid_rst_total", total_free, 64);
    chk("mid_rst_err", err_exit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
